// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg: shared types and helpers for the FIFO write-port arbiter (package fifo_arb_pkg).
package fifo_arb_pkg;
   typedef enum logic {IDLE, LOCK} state_t;
   localparam int STAT_W = 16;
   function automatic int cnt_w(input int burst_len);
      return $clog2(burst_len + 1);
   endfunction
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester handshakes plus FIFO write side; grant_cnt exists only with FIFO_ARB_STATS_EN.
interface fifo_wr_arbiter_if #(parameter int NUM_REQ = 4, parameter int WIDTH = 8, parameter int ID_W = 2);
   import fifo_arb_pkg::*;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     fifo_full;
   logic                     fifo_wr_en;
   logic [WIDTH-1:0]         fifo_data;
   logic [ID_W-1:0]          grant_id;
   logic                     busy;
`ifdef FIFO_ARB_STATS_EN
   logic [NUM_REQ*STAT_W-1:0] grant_cnt;
   modport master (input req_valid, req_data, fifo_full,
                   output req_ready, fifo_wr_en, fifo_data, grant_id, busy, grant_cnt);
   modport slave  (output req_valid, req_data, fifo_full,
                   input req_ready, fifo_wr_en, fifo_data, grant_id, busy, grant_cnt);
`else
   modport master (input req_valid, req_data, fifo_full,
                   output req_ready, fifo_wr_en, fifo_data, grant_id, busy);
   modport slave  (output req_valid, req_data, fifo_full,
                   input req_ready, fifo_wr_en, fifo_data, grant_id, busy);
`endif
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, first set request at or after start (modulo N).
module rr_pick #(parameter int N = 4, parameter int ID_W = 2) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] start,
   output logic [ID_W-1:0] winner,
   output logic            any_valid
);
   // Scan from the farthest offset down so the nearest valid request is written last.
   always_comb begin
      winner = start;
      any_valid = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(start) + k) % N]) begin
            winner = ID_W'((int'(start) + k) % N);
            any_valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst-locking arbiter sharing one FIFO write port.
// Define FIFO_ARB_STATS_EN to add saturating per-requester beat counters on grant_cnt.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 8,
   parameter int BURST_LEN = 4,
   parameter int ID_W      = 2
) (
   input logic clk,
   input logic rst_n,
   fifo_wr_arbiter_if.master bus
);
   localparam int CW = cnt_w(BURST_LEN);
   state_t state, state_nx;
   logic [ID_W-1:0] owner, owner_nx, rr_ptr, rr_nx, winner, sel;
   logic [CW-1:0] beat_cnt, beat_nx;
   logic any_valid, xfer;
   logic [NUM_REQ-1:0] ready;

   function automatic logic [ID_W-1:0] inc(input logic [ID_W-1:0] id);
      return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
   endfunction

   rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
      .req(bus.req_valid), .start(rr_ptr), .winner(winner), .any_valid(any_valid)
   );

   always_comb begin
      sel = (state == LOCK) ? owner : winner;
      xfer = rst_n && bus.req_valid[sel] && !bus.fifo_full;
      state_nx = state;
      owner_nx = owner;
      rr_nx = rr_ptr;
      beat_nx = beat_cnt;
      if (state == IDLE) begin
         if (xfer && any_valid) begin
            if (BURST_LEN == 1) rr_nx = inc(winner);
            else begin
               state_nx = LOCK;
               owner_nx = winner;
               beat_nx = CW'(1);
            end
         end
      end else if (!bus.req_valid[owner] || (xfer && (beat_cnt + 1'b1) == CW'(BURST_LEN))) begin
         state_nx = IDLE;
         rr_nx = inc(owner);
         beat_nx = '0;
      end else if (xfer) beat_nx = beat_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         owner <= '0;
         rr_ptr <= '0;
         beat_cnt <= '0;
      end else begin
         state <= state_nx;
         owner <= owner_nx;
         rr_ptr <= rr_nx;
         beat_cnt <= beat_nx;
      end
   end

   assign ready          = xfer ? (NUM_REQ'(1) << sel) : '0;
   assign bus.req_ready  = ready;
   assign bus.fifo_wr_en = xfer;
   assign bus.fifo_data  = xfer ? bus.req_data[sel*WIDTH +: WIDTH] : '0;
   assign bus.grant_id   = rst_n ? sel : '0;
   assign bus.busy       = rst_n && state == LOCK;

`ifdef FIFO_ARB_STATS_EN
   logic [NUM_REQ*STAT_W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (!rst_n) cnt <= '0;
      else
         for (int i = 0; i < NUM_REQ; i++)
            if (ready[i] && cnt[i*STAT_W +: STAT_W] != '1)
               cnt[i*STAT_W +: STAT_W] <= cnt[i*STAT_W +: STAT_W] + 1'b1;
   end
   assign bus.grant_cnt = cnt;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed checks of round-robin order, burst lock, release, stall and reset abort.
module tb_fifo_wr_arbiter;
   localparam int N = 4, W = 8, B = 4, IW = 2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) bus ();
   fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .BURST_LEN(B), .ID_W(IW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   function automatic logic [W-1:0] dat(input int i);
      return W'(160 + 17 * i);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic exp5(input string t, input logic [N-1:0] rdy, input logic we,
                       input logic [W-1:0] d, input logic [IW-1:0] g, input logic b);
      chk({t, ".ready"}, 32'(bus.req_ready), 32'(rdy));
      chk({t, ".wr_en"}, 32'(bus.fifo_wr_en), 32'(we));
      chk({t, ".data"}, 32'(bus.fifo_data), 32'(d));
      chk({t, ".grant_id"}, 32'(bus.grant_id), 32'(g));
      chk({t, ".busy"}, 32'(bus.busy), 32'(b));
   endtask

   task automatic cyc(input logic r, input logic [N-1:0] v, input logic f);
      @(negedge clk);
      rst_n = r;
      bus.req_valid = v;
      bus.fifo_full = f;
      #1;
   endtask

   initial begin
      int g;
      bus.req_valid = '0;
      bus.fifo_full = 1'b0;
      bus.req_data = {dat(3), dat(2), dat(1), dat(0)};
      cyc(0, 4'hF, 0); exp5("rst0", 0, 0, 0, 0, 0);
      cyc(0, 4'hF, 0); exp5("rst1", 0, 0, 0, 0, 0);
      for (int k = 0; k < 20; k++) begin
         cyc(1, 4'hF, 0);
         g = (k / 4) % 4;
         exp5($sformatf("rr%0d", k), N'(1 << g), 1, dat(g), IW'(g), (k % 4) != 0);
      end
      cyc(1, 4'h1, 0); exp5("t3a", 4'h1, 1, dat(0), 0, 0);
      cyc(1, 4'h1, 0); exp5("t3b", 4'h1, 1, dat(0), 0, 1);
      cyc(1, 4'h2, 0); exp5("t3rel", 0, 0, 0, 0, 1);
      cyc(1, 4'h2, 0); exp5("t3g1", 4'h2, 1, dat(1), 1, 0);
      for (int k = 1; k < 4; k++) begin
         cyc(1, 4'h2, 0); exp5($sformatf("t3g1b%0d", k), 4'h2, 1, dat(1), 1, 1);
      end
      cyc(1, 4'h8, 0); exp5("t4b1", 4'h8, 1, dat(3), 3, 0);
      cyc(1, 4'h8, 0); exp5("t4b2", 4'h8, 1, dat(3), 3, 1);
      for (int k = 0; k < 3; k++) begin
         cyc(1, 4'h8, 1); exp5($sformatf("t4full%0d", k), 0, 0, 0, 3, 1);
      end
      cyc(1, 4'h8, 0); exp5("t4b3", 4'h8, 1, dat(3), 3, 1);
      cyc(1, 4'h8, 0); exp5("t4b4", 4'h8, 1, dat(3), 3, 1);
      cyc(1, 4'h9, 1); exp5("t4idlefull", 0, 0, 0, 0, 0);
      cyc(1, 4'h9, 0); exp5("t4wrap", 4'h1, 1, dat(0), 0, 0);
      for (int k = 1; k < 4; k++) begin
         cyc(1, 4'h9, 0); exp5($sformatf("t4wrapb%0d", k), 4'h1, 1, dat(0), 0, 1);
      end
      cyc(1, 4'h0, 0); exp5("t4none", 0, 0, 0, 1, 0);
      for (int k = 0; k < 10; k++) begin
         cyc(1, 4'h4, 0);
         exp5($sformatf("t5b%0d", k), 4'h4, 1, dat(2), 2, (k % 4) != 0);
      end
      cyc(0, 4'h4, 0); exp5("t6rst", 0, 0, 0, 0, 0);
`ifdef FIFO_ARB_STATS_EN
      chk("t6cnt0", 32'(bus.grant_cnt[15:0]), 32'd14);
      chk("t6cnt1", 32'(bus.grant_cnt[31:16]), 32'd8);
      chk("t6cnt2", 32'(bus.grant_cnt[47:32]), 32'd14);
      chk("t6cnt3", 32'(bus.grant_cnt[63:48]), 32'd8);
`endif
      cyc(1, 4'hF, 0); exp5("t6after", 4'h1, 1, dat(0), 0, 0);
`ifdef FIFO_ARB_STATS_EN
      chk("t6cntclr", 32'(bus.grant_cnt == '0), 32'd1);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
